expmod_dispatch: RTL
====================

// Module: expmod_dispatch
// PURPOSE
//  Multi-channel job front-end for one exponent_modulus core (value^exponent mod modulus).
//  Accepts requests on NUM_CH valid/ready channels, arbitrates round-robin and issues one job at a time.
//  Returns each result tagged with its source channel on a single valid/ready response port.
//  Sits between key/crypto clients and the shared modexp core in the keychain datapath.
// PARAMETERS
//  WIDTH          32     operand/result width (value, modulus, exponent)
//  NUM_CH         4      request channels, >=2
//  TIMEOUT_CYCLES 65535  watchdog limit in WAIT; used only with EXPMOD_DISPATCH_TIMEOUT_EN
// PORTS
//  clk_in           in   1              single clock
//  rst_in           in   1              synchronous, active-high reset
//  req_valid_in     in   NUM_CH         per-channel request valid
//  req_ready_out    out  NUM_CH         per-channel accept; one-hot or zero
//  req_value_in     in   NUM_CH*WIDTH   packed base per channel
//  req_modulus_in   in   NUM_CH*WIDTH   packed modulus per channel
//  req_exponent_in  in   NUM_CH*WIDTH   packed exponent per channel
//  core_start_out   out  1              1-cycle start pulse to core ready_in
//  core_value_out   out  WIDTH          operand to core; held from start until core_valid_in
//  core_modulus_out out  WIDTH          as above
//  core_exponent_out out WIDTH          as above
//  core_result_in   in   WIDTH          core value_out
//  core_busy_in     in   1              core busy_out
//  core_valid_in    in   1              core valid_out, 1-cycle
//  rsp_valid_out    out  1              response valid
//  rsp_ready_in     in   1              response accept
//  rsp_chan_out     out  $clog2(NUM_CH) source channel of response
//  rsp_value_out    out  WIDTH          result
//  rsp_error_out    out  1              1 = no valid result (modulus 0 or timeout)
//  busy_out         out  1              state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, all outputs 0 (core_* operand regs 0, rsp_* 0).
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; error shortcut IDLE -> RESP.
//  IDLE: grant = first req_valid_in at/after rr pointer (wrap NUM_CH-1 -> 0);
//   req_ready_out[grant]=1 only if core_busy_in==0; combinational from valid, registered state.
//   Accept cycle: capture operands + channel; rr pointer <= grant+1 mod NUM_CH.
//   Captured modulus==0: skip core, go RESP with value 0, error 1.
//  ISSUE: core_start_out=1 for exactly this cycle; -> WAIT. Accept-to-start latency 1 cycle.
//  WAIT: on core_valid_in latch core_result_in into rsp_value_out, error 0 -> RESP.
//   core_valid_in outside WAIT ignored.
//  RESP: rsp_valid_out=1, rsp_* stable until rsp_ready_in; handshake cycle -> IDLE.
//   New accept earliest the cycle after response handshake (no overlap, one job in flight).
//  Exponent 0, modulus 1 etc. passed to core unchanged; no arithmetic in this block.
//  Request held without ready is not dropped; losing channels retain priority order.
//  Reset mid-operation: immediate return to IDLE, pending job and response discarded, no start pulse.
// CONFIGURATION
//  EXPMOD_DISPATCH_TIMEOUT_EN defined: WAIT counter (width $clog2(TIMEOUT_CYCLES+1)) cleared on
//   entry; reaching TIMEOUT_CYCLES -> RESP, value 0, error 1. Core still busy blocks next grant.
//  Not defined: no counter; WAIT lasts until core_valid_in; rsp_error_out only for modulus 0.
// STRUCTURE
//  expmod_pkg: state enum (IDLE, ISSUE, WAIT, RESP), chan_idx width helper, rsp struct
//   {chan, value, error}.
//  Sub-module rr_arbiter #(N): req vector + pointer in -> one-hot grant + index out, combinational.
//  FSM, operand/response registers, timeout counter in this module.
// TESTING (bench models core: busy/valid after fixed or random latency, computes reference modexp)
//  Single req ch0 3^4 mod 7 -> core_start 1 cycle after accept, rsp chan 0 value 4 error 0.
//  All 4 channels valid continuously, 2^10 mod 1000 -> grants 0,1,2,3,0 in order, each value 24.
//  ch2 modulus 0 -> no core_start, rsp chan 2 value 0 error 1 on next cycle.
//  rsp_ready_in low 20 cycles -> rsp_* stable, no new req_ready_out until handshake.
//  rst_in asserted in WAIT -> all outputs 0 next cycle; stale core_valid_in ignored.
//  TIMEOUT_EN, TIMEOUT_CYCLES=16, core never valid -> error rsp at 16 cycles; no grant while busy.

Source files
------------

// File: rtl/expmod_pkg.sv
// expmod_pkg: state encoding and width helpers shared by the modexp dispatcher
// and its round-robin arbiter.
package expmod_pkg;

    // Dispatcher FSM states: one job in flight from accept to response handshake.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int chan_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/expmod_dispatch_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Scans the request vector starting
// at the pointer, wrapping N-1 -> 0, and returns the first requester as a
// one-hot grant plus its index.
module rr_arbiter
    import expmod_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = chan_idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int            pos;
    logic [IW-1:0] cand;

    // First requester at or after the pointer wins; later ones keep their order.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = 0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr_i) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            cand = IW'(pos);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/expmod_dispatch.sv
// expmod_dispatch: multi-channel front-end for one shared modexp core.
// Round-robin accepts one request at a time, holds its operands on the core
// interface while the core runs, and returns the result tagged with the
// source channel. A zero modulus is answered immediately with an error.
// Optional feature macro: EXPMOD_DISPATCH_TIMEOUT_EN adds a WAIT watchdog that
// answers with an error after TIMEOUT_CYCLES cycles without a core result.
module expmod_dispatch
    import expmod_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int NUM_CH         = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [NUM_CH-1:0]                req_valid_in,
    output logic [NUM_CH-1:0]                req_ready_out,
    input  logic [NUM_CH*WIDTH-1:0]          req_value_in,
    input  logic [NUM_CH*WIDTH-1:0]          req_modulus_in,
    input  logic [NUM_CH*WIDTH-1:0]          req_exponent_in,
    output logic                             core_start_out,
    output logic [WIDTH-1:0]                 core_value_out,
    output logic [WIDTH-1:0]                 core_modulus_out,
    output logic [WIDTH-1:0]                 core_exponent_out,
    input  logic [WIDTH-1:0]                 core_result_in,
    input  logic                             core_busy_in,
    input  logic                             core_valid_in,
    output logic                             rsp_valid_out,
    input  logic                             rsp_ready_in,
    output logic [chan_idx_w(NUM_CH)-1:0]    rsp_chan_out,
    output logic [WIDTH-1:0]                 rsp_value_out,
    output logic                             rsp_error_out,
    output logic                             busy_out
);

    localparam int CHW = chan_idx_w(NUM_CH);

    if (NUM_CH < 2) begin : g_bad_num_ch
        $error("expmod_dispatch: NUM_CH must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("expmod_dispatch: TIMEOUT_CYCLES must be at least 1");
    end

    typedef struct packed {
        logic [CHW-1:0]   chan;
        logic [WIDTH-1:0] value;
        logic             error;
    } rsp_t;

    state_t           state_q, state_d;
    logic [CHW-1:0]   rr_q, rr_d;
    logic [WIDTH-1:0] op_val_q, op_val_d;
    logic [WIDTH-1:0] op_mod_q, op_mod_d;
    logic [WIDTH-1:0] op_exp_q, op_exp_d;
    rsp_t             rsp_q, rsp_d;

    logic [WIDTH-1:0] val_a [NUM_CH];
    logic [WIDTH-1:0] mod_a [NUM_CH];
    logic [WIDTH-1:0] exp_a [NUM_CH];

    logic [NUM_CH-1:0] gnt_vec;
    logic [CHW-1:0]    gnt_idx;
    logic              gnt_any;
    logic              to_hit;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign val_a[g] = req_value_in[g*WIDTH +: WIDTH];
        assign mod_a[g] = req_modulus_in[g*WIDTH +: WIDTH];
        assign exp_a[g] = req_exponent_in[g*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .N  (NUM_CH),
        .IW (CHW)
    ) u_arb (
        .req_i (req_valid_in),
        .ptr_i (rr_q),
        .gnt_o (gnt_vec),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

`ifdef EXPMOD_DISPATCH_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TOW-1:0] to_cnt_q, to_cnt_d;

    // Watchdog count: cleared while issuing, advances once per WAIT cycle.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == ST_ISSUE) begin
            to_cnt_d = '0;
        end else if (state_q == ST_WAIT) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // Watchdog register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign to_hit = (state_q == ST_WAIT) && ((to_cnt_q + 1'b1) == TOW'(TIMEOUT_CYCLES));
`else
    assign to_hit = 1'b0;
`endif

    // Next-state, capture and accept logic; only IDLE may grant, and only
    // while the core reports idle.
    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        op_val_d      = op_val_q;
        op_mod_d      = op_mod_q;
        op_exp_d      = op_exp_q;
        rsp_d         = rsp_q;
        req_ready_out = '0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any && !core_busy_in) begin
                    req_ready_out = gnt_vec;
                    op_val_d      = val_a[gnt_idx];
                    op_mod_d      = mod_a[gnt_idx];
                    op_exp_d      = exp_a[gnt_idx];
                    rsp_d.chan    = gnt_idx;
                    rr_d          = (gnt_idx == CHW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
                    if (mod_a[gnt_idx] == '0) begin
                        // No meaningful result exists; answer without the core.
                        rsp_d.value = '0;
                        rsp_d.error = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_valid_in) begin
                    rsp_d.value = core_result_in;
                    rsp_d.error = 1'b0;
                    state_d     = ST_RESP;
                end else if (to_hit) begin
                    rsp_d.value = '0;
                    rsp_d.error = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer, operand and response registers; reset drops any job.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            rr_q     <= '0;
            op_val_q <= '0;
            op_mod_q <= '0;
            op_exp_q <= '0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            op_val_q <= op_val_d;
            op_mod_q <= op_mod_d;
            op_exp_q <= op_exp_d;
            rsp_q    <= rsp_d;
        end
    end

    assign core_start_out    = (state_q == ST_ISSUE);
    assign core_value_out    = op_val_q;
    assign core_modulus_out  = op_mod_q;
    assign core_exponent_out = op_exp_q;
    assign rsp_valid_out     = (state_q == ST_RESP);
    assign rsp_chan_out      = rsp_q.chan;
    assign rsp_value_out     = rsp_q.value;
    assign rsp_error_out     = rsp_q.error;
    assign busy_out          = (state_q != ST_IDLE);

endmodule
